// File: rtl/neuron_pkg.sv
// Shared fixed-point types, FSM state encoding and saturation helper for the
// neuron multiply-accumulate stage.
package neuron_pkg;

  localparam int FRAC = 8;
  localparam int SATW = 48;

  typedef logic signed [15:0]     q88_t;
  typedef logic        [7:0]      q08_t;
  typedef logic signed [SATW-1:0] wide_t;

  typedef enum logic [1:0] {ACC, OUT, ERR, FBK} state_t;

  // Clamp any sign-extended intermediate into the Q8.8 range.
  function automatic q88_t sat16(input wide_t v);
    q88_t r;
    if (v > wide_t'(32'sd32767))
      r = 16'sh7fff;
    else if (v < wide_t'(-32'sd32768))
      r = 16'sh8000;
    else
      r = v[15:0];
    return r;
  endfunction

endpackage

// File: rtl/fxp_mul.sv
// Signed Q8.8 times signed operand, arithmetic right shift, saturate to Q8.8.
// Used for the propagated-error path and the weight-delta path.
module fxp_mul
  import neuron_pkg::*;
#(
  parameter int BW = 16,
  parameter int SH = FRAC
) (
  input  q88_t                a,
  input  logic signed [BW-1:0] b,
  output q88_t                p
);

  localparam int PW = 16 + BW;

  logic signed [PW-1:0] prod;

  assign prod = PW'(a) * PW'(b);
  assign p    = sat16(wide_t'(prod >>> SH));

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron MAC: forward dot product of N activations with N stored
// weights, optional backward pass streaming propagated errors and updating weights.
//
// state | meaning
// ACC   | accepting activation beats, accumulating w[k]*arg
// OUT   | holding saturated result until res handshake
// ERR   | waiting for downstream error (training only)
// FBK   | streaming w[k]*e upstream, updating w[k] per beat
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int          N     = 4,
  parameter int          ARGW  = 8,
  parameter int          RESW  = 16,
  parameter int          ERRW  = 16,
  parameter int          FBKW  = 16,
  parameter logic [15:0] WINIT = 16'h0100,
  parameter int          RATE  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [ARGW-1:0] arg,
  input  logic            arg_valid,
  output logic            arg_ready,
  output logic [RESW-1:0] res,
  output logic            res_valid,
  input  logic            res_ready,
  input  logic [ERRW-1:0] err,
  input  logic            err_valid,
  output logic            err_ready,
  output logic [FBKW-1:0] fbk,
  output logic            fbk_valid,
  input  logic            fbk_ready
);

  localparam int            KW    = $clog2(N);
  localparam int            ACCW  = RESW + ARGW + KW;
  localparam int            PW    = RESW + ARGW + 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  state_t                 state;
  logic [KW-1:0]          k;
  logic signed [ACCW-1:0] acc;
  q88_t                   e_reg;
  q88_t                   w [N];
  logic [ARGW-1:0]        x [N];

  logic signed [ARGW:0]   arg_s;
  logic signed [PW-1:0]   mac_prod;
  logic signed [ACCW-1:0] acc_next;
  q88_t                   mac_res;

  assign arg_s    = {1'b0, arg};
  assign mac_prod = PW'(w[k]) * PW'(arg_s);
  assign acc_next = acc + ACCW'(mac_prod);
  assign mac_res  = sat16(wide_t'(acc_next >>> FRAC));

  // Feedback is registered, so it is computed one beat ahead: entering FBK
  // needs w[0]*err, and each fbk handshake needs w[k+1]*e (still pre-update).
  logic [KW-1:0]        k_fb;
  q88_t                 e_fb;
  q88_t                 fbk_p;
  q88_t                 delta;
  q88_t                 w_upd;
  logic signed [ARGW:0] x_s;

  assign k_fb  = (state == FBK) ? k + KW'(1) : '0;
  assign e_fb  = (state == FBK) ? e_reg : q88_t'(err);
  assign x_s   = {1'b0, x[k]};
  assign w_upd = sat16(wide_t'(w[k]) - wide_t'(delta));

  fxp_mul #(.BW(ERRW), .SH(FRAC)) u_fbk_mul (
    .a (w[k_fb]),
    .b (e_fb),
    .p (fbk_p)
  );

  fxp_mul #(.BW(ARGW + 1), .SH(FRAC + RATE)) u_dlt_mul (
    .a (e_reg),
    .b (x_s),
    .p (delta)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACC;
      k         <= '0;
      acc       <= '0;
      e_reg     <= '0;
      for (int i = 0; i < N; i++) begin
        w[i] <= WINIT;
        x[i] <= '0;
      end
      arg_ready <= 1'b1;
      res_valid <= 1'b0;
      err_ready <= 1'b0;
      fbk_valid <= 1'b0;
      res       <= '0;
      fbk       <= '0;
    end else begin
      case (state)
        ACC: begin
          if (arg_valid && arg_ready) begin
            x[k] <= arg;
            if (k == KLAST) begin
              res       <= mac_res;
              k         <= '0;
              acc       <= '0;
              arg_ready <= 1'b0;
              res_valid <= 1'b1;
              state     <= OUT;
            end else begin
              acc <= acc_next;
              k   <= k + KW'(1);
            end
          end
        end
        OUT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            if (en) begin
              err_ready <= 1'b1;
              state     <= ERR;
            end else begin
              arg_ready <= 1'b1;
              state     <= ACC;
            end
          end
        end
        ERR: begin
          if (err_valid && err_ready) begin
            e_reg     <= q88_t'(err);
            err_ready <= 1'b0;
            fbk       <= fbk_p;
            fbk_valid <= 1'b1;
            k         <= '0;
            state     <= FBK;
          end
        end
        FBK: begin
          if (fbk_valid && fbk_ready) begin
            w[k] <= w_upd;
            if (k == KLAST) begin
              k         <= '0;
              fbk_valid <= 1'b0;
              arg_ready <= 1'b1;
              state     <= ACC;
            end else begin
              k   <= k + KW'(1);
              fbk <= fbk_p;
            end
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac: forward pass, saturation,
// training passes, backpressure and mid-vector reset.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  arg;
  logic        arg_valid;
  logic        res_ready;
  logic [15:0] err;
  logic        err_valid;
  logic        fbk_ready;

  logic        arg_ready, res_valid, err_ready, fbk_valid;
  logic [15:0] res, fbk;
  logic        hi_arg_ready, hi_res_valid, hi_err_ready, hi_fbk_valid;
  logic [15:0] hi_res, hi_fbk;
  logic        lo_arg_ready, lo_res_valid, lo_err_ready, lo_fbk_valid;
  logic [15:0] lo_res, lo_fbk;

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  neuron_mac u_dut (
    .clk(clk), .rst(rst), .en(en),
    .arg(arg), .arg_valid(arg_valid), .arg_ready(arg_ready),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .err(err), .err_valid(err_valid), .err_ready(err_ready),
    .fbk(fbk), .fbk_valid(fbk_valid), .fbk_ready(fbk_ready)
  );

  neuron_mac #(.WINIT(16'h7fff)) u_hi (
    .clk(clk), .rst(rst), .en(en),
    .arg(arg), .arg_valid(arg_valid), .arg_ready(hi_arg_ready),
    .res(hi_res), .res_valid(hi_res_valid), .res_ready(res_ready),
    .err(err), .err_valid(err_valid), .err_ready(hi_err_ready),
    .fbk(hi_fbk), .fbk_valid(hi_fbk_valid), .fbk_ready(fbk_ready)
  );

  neuron_mac #(.WINIT(16'h8000)) u_lo (
    .clk(clk), .rst(rst), .en(en),
    .arg(arg), .arg_valid(arg_valid), .arg_ready(lo_arg_ready),
    .res(lo_res), .res_valid(lo_res_valid), .res_ready(res_ready),
    .err(err), .err_valid(err_valid), .err_ready(lo_err_ready),
    .fbk(lo_fbk), .fbk_valid(lo_fbk_valid), .fbk_ready(fbk_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    arg_valid = 1'b0; res_ready = 1'b0; err_valid = 1'b0; fbk_ready = 1'b0; en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic put_arg(input logic [7:0] a);
    int n = 0;
    arg = a;
    arg_valid = 1'b1;
    while (arg_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("arg_wait", 32'(n < 20), 1);
    @(posedge clk); #1;
    arg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic put_vec(input logic [7:0] a);
    for (int i = 0; i < 4; i++) put_arg(a);
  endtask

  task automatic take_res(input string tag, input logic [15:0] exp, input logic en_v);
    int n = 0;
    en = en_v;
    res_ready = 1'b1;
    while (res_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_wait"}, 32'(n < 20), 1);
    chk(tag, res, exp);
    @(posedge clk); #1;
    res_ready = 1'b0;
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic put_err(input logic [15:0] e);
    int n = 0;
    err = e;
    err_valid = 1'b1;
    while (err_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("err_wait", 32'(n < 20), 1);
    @(posedge clk); #1;
    err_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic take_fbk(input string tag, input logic [15:0] exp);
    int n = 0;
    fbk_ready = 1'b1;
    while (fbk_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_wait"}, 32'(n < 20), 1);
    chk(tag, fbk, exp);
    @(posedge clk); #1;
    fbk_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    arg = '0; err = '0;
    do_reset();

    // reset state
    chk("rst_arg_ready", arg_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err_ready", err_ready, 0);
    chk("rst_fbk_valid", fbk_valid, 0);
    chk("rst_res", res, 16'h0000);
    chk("rst_fbk", fbk, 16'h0000);

    // saturation: 0x7fff*255*4>>8 and 0x8000*255*4>>8 overflow; 0x100*255*4>>8 = 0x3fc
    put_vec(8'hff);
    chk("sat_hi", hi_res, 16'h7fff);
    chk("sat_lo", lo_res, 16'h8000);
    take_res("sat_mid", 16'h03fc, 1'b0);

    // plain forward pass with latency check
    for (int i = 0; i < 3; i++) put_arg(8'h80);
    chk("lat_pre", res_valid, 0);
    put_arg(8'h80);
    chk("lat_post", res_valid, 1);
    take_res("fwd_80", 16'h0200, 1'b0);

    // training with e=+1.0: fbk 1.0, weights 1.0 -> 0.5
    put_vec(8'h80);
    take_res("trn_pos_res", 16'h0200, 1'b1);
    chk("trn_pos_arg_ready", arg_ready, 0);
    put_err(16'h0100);
    for (int i = 0; i < 4; i++) take_fbk("trn_pos_fbk", 16'h0100);
    put_vec(8'h80);
    take_res("trn_pos_after", 16'h0100, 1'b0);

    // training with e=-1.0 from fresh weights: weights 1.0 -> 1.5
    do_reset();
    put_vec(8'h80);
    take_res("trn_neg_res", 16'h0200, 1'b1);
    put_err(16'hff00);
    for (int i = 0; i < 4; i++) take_fbk("trn_neg_fbk", 16'hff00);
    put_vec(8'h80);
    take_res("trn_neg_after", 16'h0300, 1'b0);

    // backpressure on res and fbk
    do_reset();
    put_vec(8'h80);
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res", res, 16'h0200);
      chk("bp_res_arg_ready", arg_ready, 0);
      chk("bp_res_err_ready", err_ready, 0);
      @(negedge clk);
    end
    take_res("bp_res_final", 16'h0200, 1'b1);
    put_err(16'h0100);
    take_fbk("bp_fbk0", 16'h0100);
    for (int i = 0; i < 3; i++) begin
      chk("bp_fbk_valid", fbk_valid, 1);
      chk("bp_fbk", fbk, 16'h0100);
      chk("bp_fbk_arg_ready", arg_ready, 0);
      chk("bp_fbk_err_ready", err_ready, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) take_fbk("bp_fbk_rest", 16'h0100);
    put_vec(8'h80);
    take_res("bp_after", 16'h0100, 1'b0);

    // mid-vector reset: weights (currently 0.5) return to WINIT
    put_arg(8'h80);
    put_arg(8'h80);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_res_valid", res_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_arg_ready", arg_ready, 1);
    chk("mid_res_valid", res_valid, 0);
    chk("mid_err_ready", err_ready, 0);
    chk("mid_fbk_valid", fbk_valid, 0);
    put_vec(8'h80);
    take_res("mid_fresh", 16'h0200, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
